clkdiv_prog: RTL and testbench

//  Multi-channel clock divider with runtime-programmable divisors, replacing fixed-DIV clkdiv instances.

---
 rtl/clkdiv_prog.sv | 116 +++++++++++
 tb/tb_clkdiv_prog.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_prog.sv
// clkdiv_prog: multi-channel clock divider with runtime-programmable divisors.
// Each channel produces a 50%-duty divided clock (period 2*D) and a one-cycle
// tick (period D). A new divisor written to a running channel is held in a
// shadow register and takes effect at that channel's next wrap, so the
// outputs never glitch. syncIn restarts every channel at phase 0.
//
// Write port: a write is a single-cycle strobe with no back-pressure. On
// every rising edge where wrEn is high, wrDiv is consumed by channel wrCh.
// An out-of-range wrCh (>= N) matches no channel and is dropped. There is
// no ready; the port accepts a write every cycle.
module clkdiv_prog #(
    parameter int N         = 4,
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 1,
    localparam int CH_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clkIn,
    input  logic             rstN,
    input  logic             syncIn,
    input  logic             wrEn,
    input  logic [CH_W-1:0]  wrCh,
    input  logic [WIDTH-1:0] wrDiv,
    output logic [N-1:0]     clkOut,
    output logic [N-1:0]     tickOut,
    output logic [N-1:0]     pending
);

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(RESET_DIV);

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] nxt;
        logic             pend;
        logic             clk_q;
        logic             tick_q;
        logic             hit;
        logic             disabled;
        logic             wrap;

        // Decode the write target and the channel's period boundary.
        always_comb begin
            hit      = wrEn && (wrCh == CH_W'(i));
            disabled = (div == '0);
            // div == 0 is handled before this is used, so the underflow
            // of div - 1 never matters.
            wrap     = (cnt == (div - ONE));
        end

        // Per-channel counter, divisor shadow and output registers.
        // Priority: sync, disabled, wrap, count. A write to a running
        // channel is captured last so it overrides the wrap's pend clear.
        always_ff @(posedge clkIn or negedge rstN) begin
            if (!rstN) begin
                cnt    <= '0;
                div    <= DIV_RESET;
                nxt    <= '0;
                pend   <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (syncIn) begin
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                pend   <= 1'b0;
                if (hit) begin
                    div <= wrDiv;
                end else if (pend) begin
                    div <= nxt;
                end
            end else if (disabled) begin
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                // A stopped channel has no period to protect, so a write
                // (or a shadow left over from a wrap that disabled it)
                // applies at once.
                if (hit) begin
                    div  <= wrDiv;
                    pend <= 1'b0;
                end else if (pend) begin
                    div  <= nxt;
                    pend <= 1'b0;
                end
            end else begin
                if (wrap) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    if (pend) begin
                        div  <= nxt;
                        pend <= 1'b0;
                        // Switching to disabled parks the clock low.
                        clk_q <= (nxt == '0) ? 1'b0 : ~clk_q;
                    end else begin
                        clk_q <= ~clk_q;
                    end
                end else begin
                    cnt    <= cnt + ONE;
                    tick_q <= 1'b0;
                end
                // Same-edge write lands in the shadow; the divisor just
                // applied (or kept) governs one more full period.
                if (hit) begin
                    nxt  <= wrDiv;
                    pend <= 1'b1;
                end
            end
        end

        assign clkOut[i]  = clk_q;
        assign tickOut[i] = tick_q;
        assign pending[i] = pend;
    end

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: drives two divider instances (N=4/WIDTH=16/RESET_DIV=1 and
// N=3/WIDTH=4/RESET_DIV=0) from a shared write port and compares every cycle
// against a period-based reference model, plus directed literal checks.
module tb_clkdiv_prog;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic [3:0]  clk_out_a, tick_out_a, pending_a;
    logic [2:0]  clk_out_b, tick_out_b, pending_b;

    always #5 clk = ~clk;

    clkdiv_prog #(.N(4), .WIDTH(16), .RESET_DIV(1)) dut_a (
        .clkIn(clk), .rstN(rst_n), .syncIn(sync), .wrEn(wr_en),
        .wrCh(wr_ch), .wrDiv(wr_div),
        .clkOut(clk_out_a), .tickOut(tick_out_a), .pending(pending_a)
    );

    clkdiv_prog #(.N(3), .WIDTH(4), .RESET_DIV(0)) dut_b (
        .clkIn(clk), .rstN(rst_n), .syncIn(sync), .wrEn(wr_en),
        .wrCh(wr_ch), .wrDiv(wr_div[3:0]),
        .clkOut(clk_out_b), .tickOut(tick_out_b), .pending(pending_b)
    );

    wire [20:0] dut_vec = {pending_b, tick_out_b, clk_out_b,
                           pending_a, tick_out_a, clk_out_a};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Channels 0..3 belong to instance A, 4..6 to instance B. Each channel
    // is described by its divisor, a queued divisor, edges elapsed in the
    // current period and the current output levels.
    localparam int NM = 7;
    int m_div[NM];
    int m_q[NM];
    int m_el[NM];
    bit m_hq[NM];
    bit m_lvl[NM];
    bit m_tick[NM];

    task automatic model_reset();
        for (int k = 0; k < NM; k++) begin
            m_div[k]  = (k >= 4) ? 0 : 1;
            m_q[k]    = 0;
            m_el[k]   = 0;
            m_hq[k]   = 1'b0;
            m_lvl[k]  = 1'b0;
            m_tick[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit s, input bit w, input int ch, input int d);
        for (int k = 0; k < NM; k++) begin
            int idx;
            int dd;
            bit hit;
            idx = (k >= 4) ? k - 4 : k;
            dd  = (k >= 4) ? (d % 16) : (d % 65536);
            hit = w && (ch == idx);
            if (s) begin
                if (hit) m_div[k] = dd;
                else if (m_hq[k]) m_div[k] = m_q[k];
                m_hq[k] = 1'b0; m_el[k] = 0; m_lvl[k] = 1'b0; m_tick[k] = 1'b0;
            end else if (m_div[k] == 0) begin
                m_el[k] = 0; m_lvl[k] = 1'b0; m_tick[k] = 1'b0;
                if (hit) begin
                    m_div[k] = dd; m_hq[k] = 1'b0;
                end else if (m_hq[k]) begin
                    m_div[k] = m_q[k]; m_hq[k] = 1'b0;
                end
            end else begin
                m_el[k]++;
                if (m_el[k] == m_div[k]) begin
                    m_el[k] = 0;
                    m_tick[k] = 1'b1;
                    if (m_hq[k]) begin
                        m_div[k] = m_q[k];
                        m_hq[k] = 1'b0;
                        m_lvl[k] = (m_div[k] == 0) ? 1'b0 : !m_lvl[k];
                    end else begin
                        m_lvl[k] = !m_lvl[k];
                    end
                end else begin
                    m_tick[k] = 1'b0;
                end
                if (hit) begin
                    m_q[k] = dd; m_hq[k] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [20:0] model_vec();
        logic [20:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            v[k] = m_lvl[k]; v[4+k] = m_tick[k]; v[8+k] = m_hq[k];
        end
        for (int k = 0; k < 3; k++) begin
            v[12+k] = m_lvl[4+k]; v[15+k] = m_tick[4+k]; v[18+k] = m_hq[4+k];
        end
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [20:0] exp_q[$];

    // Compare every stepped cycle on the falling edge.
    initial begin
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle_outputs", 32'(dut_vec), 32'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit s, input bit w, input int ch, input int d);
        logic [31:0] dv;
        logic [31:0] cv;
        dv = d; cv = ch;
        sync = s; wr_en = w; wr_ch = cv[1:0]; wr_div = dv[15:0];
        @(posedge clk);
        model_step(s, w, ch, d);
        exp_q.push_back(model_vec());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0);
    endtask

    // Edges until the selected tick is next seen high (-1 if not within 40).
    task automatic measure_gap(input bit inst_b, input int bit_n, output int gap);
        gap = -1;
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, 1'b0, 0, 0);
            if (inst_b ? tick_out_b[bit_n] : tick_out_a[bit_n]) begin
                gap = i;
                break;
            end
        end
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'(dut_vec), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g;
        logic [9:0] hist;
        int hi_cnt;
        rst_n = 1'b1; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        #3 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", 32'(dut_vec), 32'd0);
        rst_n = 1'b1;

        // D=1 from reset: clocks toggle every edge, ticks continuous.
        idle(1);
        check("d1_tick_a", 32'(tick_out_a), 32'hF);
        check("d1_clk_a_hi", 32'(clk_out_a), 32'hF);
        check("b_disabled", 32'({tick_out_b, clk_out_b}), 32'd0);
        idle(1);
        check("d1_clk_a_lo", 32'(clk_out_a), 32'h0);
        check("d1_tick_a2", 32'(tick_out_a), 32'hF);

        // ch1 D=5: pending until next wrap, then period 5 / 10.
        cycle(1'b0, 1'b1, 1, 5);
        check("ch1_pending_set", 32'(pending_a[1]), 32'd1);
        idle(1);
        check("ch1_pending_clr", 32'(pending_a[1]), 32'd0);
        hist = '0; hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            hist[i] = tick_out_a[1];
            hi_cnt += int'(clk_out_a[1]);
        end
        check("ch1_tick_pattern", 32'(hist), 32'b10000_10000);
        check("ch1_clk_high_cycles", 32'(hi_cnt), 32'd5);

        // ch2: last write before wrap wins, same-edge write waits a period.
        cycle(1'b0, 1'b1, 2, 10);
        idle(1);
        cycle(1'b0, 1'b1, 2, 4);
        cycle(1'b0, 1'b1, 2, 7);
        check("ch2_pending", 32'(pending_a[2]), 32'd1);
        measure_gap(1'b0, 2, g);
        check("ch2_gap_d10_rest", 32'(g), 32'd8);
        measure_gap(1'b0, 2, g);
        check("ch2_gap_d7", 32'(g), 32'd7);
        idle(6);
        cycle(1'b0, 1'b1, 2, 3);
        check("ch2_wrap_with_write", 32'({tick_out_a[2], pending_a[2]}), 32'b11);
        measure_gap(1'b0, 2, g);
        check("ch2_gap_old_d7", 32'(g), 32'd7);
        measure_gap(1'b0, 2, g);
        check("ch2_gap_d3", 32'(g), 32'd3);

        // ch0 D=0: one last tick, then silent; D=2 resumes two edges later.
        cycle(1'b0, 1'b1, 0, 0);
        idle(1);
        check("ch0_last_tick", 32'({tick_out_a[0], clk_out_a[0]}), 32'b10);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("ch0_disabled", 32'({tick_out_a[0], clk_out_a[0]}), 32'b00);
        end
        cycle(1'b0, 1'b1, 0, 2);
        check("ch0_immediate_no_pend", 32'({pending_a[0], tick_out_a[0]}), 32'b00);
        idle(1);
        check("ch0_resume_1", 32'(tick_out_a[0]), 32'd0);
        idle(1);
        check("ch0_resume_2", 32'(tick_out_a[0]), 32'd1);

        // sync realigns D=3,4,6 channels: joint ticks at edge 12.
        cycle(1'b0, 1'b1, 1, 3);
        cycle(1'b0, 1'b1, 2, 4);
        cycle(1'b0, 1'b1, 3, 6);
        idle(2);
        cycle(1'b1, 1'b0, 0, 0);
        check("sync_clear", 32'({pending_a, tick_out_a, clk_out_a}), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            if (i == 6) check("sync_edge6", 32'(tick_out_a[3:1]), 32'b101);
            if (i == 12) check("sync_edge12", 32'(tick_out_a[3:1]), 32'b111);
        end
        cycle(1'b1, 1'b1, 3, 9);
        measure_gap(1'b0, 3, g);
        check("sync_write_d9", 32'(g), 32'd9);

        // Out-of-range channel on the 3-channel instance; max divisor on 4 bits.
        cycle(1'b0, 1'b1, 3, 15);
        check("b_invalid_ch", 32'(pending_b), 32'd0);
        cycle(1'b1, 1'b1, 0, 15);
        measure_gap(1'b1, 0, g);
        check("b_d15_gap1", 32'(g), 32'd15);
        measure_gap(1'b1, 0, g);
        check("b_d15_gap2", 32'(g), 32'd15);

        // Reset mid-period, then D=1 behaviour again.
        idle(4);
        async_reset();
        idle(1);
        check("post_reset_tick", 32'(tick_out_a), 32'hF);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit s;
            bit w;
            int ch;
            int d;
            int r;
            s  = ($urandom_range(0, 49) == 0);
            w  = ($urandom_range(0, 3) == 0);
            ch = $urandom_range(0, 3);
            r  = $urandom_range(0, 9);
            d  = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(1, 12));
            cycle(s, w, ch, d);
            if ($urandom_range(0, 599) == 0) async_reset();
        end

        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
